// File: rtl/raytrace_pkg.sv
`default_nettype none
// ============================================================================
// Package     : raytrace_pkg
// Description : Shared fixed-point types, hit record and FSM state encoding
//               for the ray-traversal pipeline stages.
// Revision    : 1.0 - initial release
// ============================================================================
package raytrace_pkg;

    // Signed Q16.16 fixed-point value
    typedef logic signed [31:0] fip32_t;

    localparam fip32_t FIP_ONE = 32'sh0001_0000;

    // Triangle index width carried in the shared hit record
    localparam int HIT_ID_W = 16;

    // Closest-hit record as held by the reduction stage
    typedef struct packed {
        logic                hit;
        fip32_t              t;
        fip32_t              a;
        fip32_t              b;
        logic [HIT_ID_W-1:0] tri_id;
    } hit_rec_t;

    // Reduction stage state: collecting beats, or presenting the record
    typedef enum logic [0:0] {
        ST_ACCUM  = 1'b0,
        ST_RESULT = 1'b1
    } ch_state_e;

endpackage : raytrace_pkg
`default_nettype wire

// File: rtl/closest_hit_if.sv
`default_nettype none
// ============================================================================
// Interface   : closest_hit_if
// Description : Upstream beat stream (per-triangle verdicts) and downstream
//               closest-hit record channel of the closest_hit stage.
//               slave  = the reduction stage, master = its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface closest_hit_if
    import raytrace_pkg::*;
#(
    parameter int ID_W  = 16,
    parameter int CNT_W = 16
) ();

    // Upstream beat channel
    logic            i_valid;
    logic            o_ready;
    logic            i_hit;
    logic            i_overflow;
    fip32_t          i_t;
    fip32_t          i_a;
    fip32_t          i_b;
    logic [ID_W-1:0] i_tri_id;
    logic            i_last;

    // Downstream record channel
    logic             o_valid;
    logic             i_ready;
    logic             o_hit;
    fip32_t           o_t;
    fip32_t           o_a;
    fip32_t           o_b;
    logic [ID_W-1:0]  o_tri_id;
    logic             o_ovf;
    logic [CNT_W-1:0] o_count;

    modport slave (
        input  i_valid, i_hit, i_overflow, i_t, i_a, i_b, i_tri_id, i_last,
        input  i_ready,
        output o_ready,
        output o_valid, o_hit, o_t, o_a, o_b, o_tri_id, o_ovf, o_count
    );

    modport master (
        output i_valid, i_hit, i_overflow, i_t, i_a, i_b, i_tri_id, i_last,
        output i_ready,
        input  o_ready,
        input  o_valid, o_hit, o_t, o_a, o_b, o_tri_id, o_ovf, o_count
    );

endinterface : closest_hit_if
`default_nettype wire

// File: rtl/closest_hit_cmp.sv
`default_nettype none
// ============================================================================
// Module      : closest_hit_cmp
// Description : Combinational hit-ordering rule. Decides whether a beat is a
//               usable hit and whether it beats the current best record.
// Revision    : 1.0 - initial release
// ============================================================================
module closest_hit_cmp
    import raytrace_pkg::*;
#(
    parameter fip32_t T_MAX = 32'sh7FFF_FFFF
) (
    input  logic   i_hit,
    input  logic   i_overflow,
    input  fip32_t i_t,
    input  logic   i_have_hit,
    input  fip32_t i_best_t,
    output logic   o_qualify,
    output logic   o_replace
);

    // Overflowed determinants give meaningless t, so they never qualify.
    // Both operands are fip32_t, so the comparisons are signed.
    assign o_qualify = i_hit && !i_overflow && (i_t <= T_MAX);

    // Strict less-than keeps the earlier triangle when t values tie.
    assign o_replace = o_qualify && (!i_have_hit || (i_t < i_best_t));

endmodule : closest_hit_cmp
`default_nettype wire

// File: rtl/closest_hit.sv
`default_nettype none
// ============================================================================
// Module      : closest_hit
// Description : Per-ray closest-hit reduction. Consumes one intersection
//               verdict per triangle, keeps the nearest qualifying hit, and
//               after the last beat presents a single record downstream.
// Revision    : 1.0 - initial release
// ============================================================================
module closest_hit
    import raytrace_pkg::*;
#(
    parameter int     ID_W  = HIT_ID_W,
    parameter int     CNT_W = 16,
    parameter fip32_t T_MAX = 32'sh7FFF_FFFF
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    closest_hit_if.slave bus
);

    // Empty record: no hit, t parked at the far clip, everything else zero
    localparam hit_rec_t c_REC_EMPTY = '{
        hit    : 1'b0,
        t      : T_MAX,
        a      : 32'sh0,
        b      : 32'sh0,
        tri_id : '0
    };

    ch_state_e        state_q;
    hit_rec_t         best_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             ovf_q;

    logic             w_accept;
    logic             w_qualify;
    logic             w_replace;

    // ------------------------------------------------------------------
    // Ordering rule lives in its own block so other stages can share it
    // ------------------------------------------------------------------
    closest_hit_cmp #(
        .T_MAX (T_MAX)
    ) u_cmp (
        .i_hit      (bus.i_hit),
        .i_overflow (bus.i_overflow),
        .i_t        (bus.i_t),
        .i_have_hit (best_q.hit),
        .i_best_t   (best_q.t),
        .o_qualify  (w_qualify),
        .o_replace  (w_replace)
    );

    assign w_accept = bus.i_valid && (state_q == ST_ACCUM);

    // Beat counter sticks at all-ones rather than wrapping
    always_comb begin
        count_d = count_q;
        if (!(&count_q)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Stage FSM plus the accumulated record, counter and overflow summary
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_ACCUM;
            best_q  <= c_REC_EMPTY;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (w_accept) begin
                        count_q <= count_d;
                        ovf_q   <= ovf_q | bus.i_overflow;
                        // Any qualifying beat means the ray has a hit; when
                        // none was held yet, the same beat also replaces.
                        best_q.hit <= best_q.hit | w_qualify;
                        if (w_replace) begin
                            best_q.t      <= bus.i_t;
                            best_q.a      <= bus.i_a;
                            best_q.b      <= bus.i_b;
                            best_q.tri_id <= HIT_ID_W'(bus.i_tri_id);
                        end
                        if (bus.i_last) begin
                            state_q <= ST_RESULT;
                        end
                    end
                end
                ST_RESULT: begin
                    // Record taken: start the next ray from an empty record
                    if (bus.i_ready) begin
                        best_q  <= c_REC_EMPTY;
                        count_q <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= ST_ACCUM;
                    end
                end
                default: begin
                    state_q <= ST_ACCUM;
                end
            endcase
        end
    end

    // All outputs come straight from registers or a state decode
    assign bus.o_ready  = (state_q == ST_ACCUM);
    assign bus.o_valid  = (state_q == ST_RESULT);
    assign bus.o_hit    = best_q.hit;
    assign bus.o_t      = best_q.t;
    assign bus.o_a      = best_q.a;
    assign bus.o_b      = best_q.b;
    assign bus.o_tri_id = ID_W'(best_q.tri_id);
    assign bus.o_ovf    = ovf_q;
    assign bus.o_count  = count_q;

endmodule : closest_hit
`default_nettype wire

// File: tb/tb_closest_hit.sv
`default_nettype none
// ============================================================================
// Module      : tb_closest_hit
// Description : Directed self-checking bench for the closest_hit stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_closest_hit;
    import raytrace_pkg::*;

    localparam fip32_t C_TMAX = 32'sh7FFF_FFFF;

    logic clk;
    logic rstn;
    int   total;
    int   bad;

    closest_hit_if #(.ID_W(16), .CNT_W(16)) bus ();

    closest_hit #(
        .ID_W  (16),
        .CNT_W (16),
        .T_MAX (C_TMAX)
    ) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one beat starting just after a falling edge; returns one
    // falling edge later with i_valid dropped. a = 1.0 + id, b = id.
    task automatic drive_beat(input logic hit, input logic ovf, input fip32_t t,
                              input logic [15:0] id, input logic last);
        int guard;
        guard = 0;
        while (bus.o_ready !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (bus.o_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL beat_ready_timeout: o_ready=%b want 1", bus.o_ready);
        end
        bus.i_valid    = 1'b1;
        bus.i_hit      = hit;
        bus.i_overflow = ovf;
        bus.i_t        = t;
        bus.i_a        = FIP_ONE + fip32_t'({16'h0, id});
        bus.i_b        = fip32_t'({16'h0, id});
        bus.i_tri_id   = id;
        bus.i_last     = last;
        @(negedge clk);
        bus.i_valid    = 1'b0;
        bus.i_last     = 1'b0;
    endtask

    task automatic handshake();
        bus.i_ready = 1'b1;
        @(negedge clk);
        bus.i_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.o_valid); end
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", bus.o_ready); end
        total++; if (bus.o_hit !== 1'b0) begin bad++; $display("FAIL rst_hit: got %b want 0", bus.o_hit); end
        total++; if (bus.o_ovf !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", bus.o_ovf); end
        total++; if (bus.o_count !== 16'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", bus.o_count); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_three_beat();
        drive_beat(1'b1, 1'b0, 32'sh0005_0000, 16'd1, 1'b0);
        drive_beat(1'b1, 1'b0, 32'sh0002_0000, 16'd2, 1'b0);
        drive_beat(1'b1, 1'b0, 32'sh0003_0000, 16'd3, 1'b1);
        total++; if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL three_latency_valid: got %b want 1", bus.o_valid); end
        total++; if (bus.o_hit !== 1'b1) begin bad++; $display("FAIL three_hit: got %b want 1", bus.o_hit); end
        total++; if (bus.o_t !== 32'sh0002_0000) begin bad++; $display("FAIL three_t: got %h want 00020000", bus.o_t); end
        total++; if (bus.o_tri_id !== 16'd2) begin bad++; $display("FAIL three_id: got %0d want 2", bus.o_tri_id); end
        total++; if (bus.o_a !== 32'sh0001_0002) begin bad++; $display("FAIL three_a: got %h want 00010002", bus.o_a); end
        total++; if (bus.o_b !== 32'sh0000_0002) begin bad++; $display("FAIL three_b: got %h want 00000002", bus.o_b); end
        total++; if (bus.o_count !== 16'd3) begin bad++; $display("FAIL three_count: got %0d want 3", bus.o_count); end
        total++; if (bus.o_ovf !== 1'b0) begin bad++; $display("FAIL three_ovf: got %b want 0", bus.o_ovf); end
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL three_ready: got %b want 0", bus.o_ready); end
        handshake();
        total++; if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL three_drop_valid: got %b want 0", bus.o_valid); end
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL three_bubble_ready: got %b want 1", bus.o_ready); end
        total++; if (bus.o_count !== 16'd0) begin bad++; $display("FAIL three_clear_count: got %0d want 0", bus.o_count); end
    endtask

    task automatic test_no_hit();
        drive_beat(1'b0, 1'b0, 32'sh0001_0000, 16'd4, 1'b0);
        drive_beat(1'b0, 1'b0, -32'sh0002_0000, 16'd5, 1'b0);
        drive_beat(1'b0, 1'b0, 32'sh0000_8000, 16'd6, 1'b1);
        total++; if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL nohit_valid: got %b want 1", bus.o_valid); end
        total++; if (bus.o_hit !== 1'b0) begin bad++; $display("FAIL nohit_hit: got %b want 0", bus.o_hit); end
        total++; if (bus.o_t !== C_TMAX) begin bad++; $display("FAIL nohit_t: got %h want 7fffffff", bus.o_t); end
        total++; if (bus.o_tri_id !== 16'd0) begin bad++; $display("FAIL nohit_id: got %0d want 0", bus.o_tri_id); end
        total++; if (bus.o_a !== 32'sh0 || bus.o_b !== 32'sh0) begin bad++; $display("FAIL nohit_ab: got %h/%h want 0/0", bus.o_a, bus.o_b); end
        total++; if (bus.o_ovf !== 1'b0) begin bad++; $display("FAIL nohit_ovf: got %b want 0", bus.o_ovf); end
        total++; if (bus.o_count !== 16'd3) begin bad++; $display("FAIL nohit_count: got %0d want 3", bus.o_count); end
        handshake();
    endtask

    task automatic test_tie();
        drive_beat(1'b1, 1'b0, 32'sh0001_0000, 16'd7, 1'b0);
        drive_beat(1'b1, 1'b0, 32'sh0001_0000, 16'd9, 1'b1);
        total++; if (bus.o_tri_id !== 16'd7) begin bad++; $display("FAIL tie_id: got %0d want 7", bus.o_tri_id); end
        total++; if (bus.o_t !== 32'sh0001_0000) begin bad++; $display("FAIL tie_t: got %h want 00010000", bus.o_t); end
        handshake();
    endtask

    task automatic test_overflow();
        drive_beat(1'b1, 1'b1, 32'sh0000_8000, 16'd4, 1'b0);
        drive_beat(1'b1, 1'b0, 32'sh0004_0000, 16'd5, 1'b1);
        total++; if (bus.o_t !== 32'sh0004_0000) begin bad++; $display("FAIL ovf_t: got %h want 00040000", bus.o_t); end
        total++; if (bus.o_tri_id !== 16'd5) begin bad++; $display("FAIL ovf_id: got %0d want 5", bus.o_tri_id); end
        total++; if (bus.o_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %b want 1", bus.o_ovf); end
        total++; if (bus.o_hit !== 1'b1) begin bad++; $display("FAIL ovf_hit: got %b want 1", bus.o_hit); end
        handshake();
        total++; if (bus.o_ovf !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b want 0", bus.o_ovf); end
    endtask

    task automatic test_signed_and_clip();
        // Negative t is nearer than positive t under a signed compare
        drive_beat(1'b1, 1'b0, 32'sh0002_0000, 16'd1, 1'b0);
        drive_beat(1'b1, 1'b0, -32'sh0001_0000, 16'd2, 1'b1);
        total++; if (bus.o_t !== 32'shFFFF_0000) begin bad++; $display("FAIL signed_t: got %h want ffff0000", bus.o_t); end
        total++; if (bus.o_tri_id !== 16'd2) begin bad++; $display("FAIL signed_id: got %0d want 2", bus.o_tri_id); end
        handshake();
        // t exactly at the far clip still qualifies (single-beat ray)
        drive_beat(1'b1, 1'b0, C_TMAX, 16'd3, 1'b1);
        total++; if (bus.o_hit !== 1'b1) begin bad++; $display("FAIL clip_hit: got %b want 1", bus.o_hit); end
        total++; if (bus.o_tri_id !== 16'd3) begin bad++; $display("FAIL clip_id: got %0d want 3", bus.o_tri_id); end
        total++; if (bus.o_count !== 16'd1) begin bad++; $display("FAIL clip_count: got %0d want 1", bus.o_count); end
        handshake();
    endtask

    task automatic test_backpressure();
        logic stable_ok;
        drive_beat(1'b1, 1'b0, 32'sh0006_0000, 16'd11, 1'b1);
        // Keep a tempting beat on the input the whole time
        bus.i_valid    = 1'b1;
        bus.i_hit      = 1'b1;
        bus.i_overflow = 1'b0;
        bus.i_t        = 32'sh0000_0001;
        bus.i_tri_id   = 16'd99;
        bus.i_last     = 1'b1;
        for (int i = 0; i < 10; i++) begin
            stable_ok = (bus.o_valid === 1'b1) && (bus.o_ready === 1'b0) &&
                        (bus.o_t === 32'sh0006_0000) && (bus.o_tri_id === 16'd11) &&
                        (bus.o_count === 16'd1);
            total++;
            if (!stable_ok) begin
                bad++;
                $display("FAIL bp_hold cycle %0d: valid=%b ready=%b t=%h id=%0d count=%0d want 1 0 00060000 11 1",
                         i, bus.o_valid, bus.o_ready, bus.o_t, bus.o_tri_id, bus.o_count);
            end
            @(negedge clk);
        end
        handshake();
        bus.i_valid = 1'b0;
        bus.i_last  = 1'b0;
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after: got %b want 1", bus.o_ready); end
        total++; if (bus.o_count !== 16'd0) begin bad++; $display("FAIL bp_no_consume: got %0d want 0", bus.o_count); end
        total++; if (bus.o_hit !== 1'b0) begin bad++; $display("FAIL bp_hit_clear: got %b want 0", bus.o_hit); end
    endtask

    task automatic test_reset_midray();
        drive_beat(1'b1, 1'b1, 32'sh0001_0000, 16'd20, 1'b0);
        drive_beat(1'b1, 1'b0, 32'sh0002_0000, 16'd21, 1'b0);
        rstn = 1'b0;
        #1;
        total++; if (bus.o_hit !== 1'b0) begin bad++; $display("FAIL mid_rst_hit: got %b want 0", bus.o_hit); end
        total++; if (bus.o_count !== 16'd0) begin bad++; $display("FAIL mid_rst_count: got %0d want 0", bus.o_count); end
        total++; if (bus.o_ovf !== 1'b0) begin bad++; $display("FAIL mid_rst_ovf: got %b want 0", bus.o_ovf); end
        total++; if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_hs: ready=%b valid=%b want 1 0", bus.o_ready, bus.o_valid); end
        total++; if (bus.o_t !== C_TMAX) begin bad++; $display("FAIL mid_rst_t: got %h want 7fffffff", bus.o_t); end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        drive_beat(1'b1, 1'b0, 32'sh0003_0000, 16'd30, 1'b1);
        total++; if (bus.o_t !== 32'sh0003_0000) begin bad++; $display("FAIL post_rst_t: got %h want 00030000", bus.o_t); end
        total++; if (bus.o_tri_id !== 16'd30) begin bad++; $display("FAIL post_rst_id: got %0d want 30", bus.o_tri_id); end
        total++; if (bus.o_count !== 16'd1) begin bad++; $display("FAIL post_rst_count: got %0d want 1", bus.o_count); end
        total++; if (bus.o_ovf !== 1'b0) begin bad++; $display("FAIL post_rst_ovf: got %b want 0", bus.o_ovf); end
        handshake();
    endtask

    initial begin
        total          = 0;
        bad            = 0;
        rstn           = 1'b0;
        bus.i_valid    = 1'b0;
        bus.i_hit      = 1'b0;
        bus.i_overflow = 1'b0;
        bus.i_t        = 32'sh0;
        bus.i_a        = 32'sh0;
        bus.i_b        = 32'sh0;
        bus.i_tri_id   = 16'd0;
        bus.i_last     = 1'b0;
        bus.i_ready    = 1'b0;

        test_reset();
        test_three_beat();
        test_no_hit();
        test_tie();
        test_overflow();
        test_signed_and_clip();
        test_backpressure();
        test_reset_midray();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_closest_hit
`default_nettype wire

// File: doc/closest_hit.md
# closest_hit

Per-ray reduction stage directly downstream of the ray/triangle intersection test. It accepts a stream of per-triangle intersection verdicts for one ray, one beat per triangle, and keeps the nearest valid hit. After the beat flagged last, it presents one closest-hit record (hit flag, t, triangle id, barycentrics, overflow summary) to the shading stage over a valid/ready handshake.

## Interface
- `ID_W`, 16: triangle index width.
- `CNT_W`, 16: width of the per-ray triangle counter.
- `T_MAX`, 32'sh7FFF_FFFF: far clip; hits with t > T_MAX are discarded (Q16.16 signed).

- `i_clk`  in  1  clock; all state on its rising edge.
- `i_rstn`  in  1  reset; asynchronous, active-low.
- `i_valid`  in  1  upstream beat valid.
- `o_ready`  out  1  stage can accept a beat.
- `i_hit`  in  1  intersection verdict for this triangle.
- `i_overflow`  in  1  determinant overflow for this triangle.
- `i_t`, `i_a`, `i_b`  in  32 each  signed Q16.16 ray parameter and barycentrics.
- `i_tri_id`  in  ID_W  triangle index.
- `i_last`  in  1  final triangle of the current ray.
- `o_valid`  out  1  closest-hit record valid.
- `i_ready`  in  1  downstream accepts the record.
- `o_hit`  out  1  at least one qualifying hit.
- `o_t`, `o_a`, `o_b`  out  32 each  nearest hit values (Q16.16).
- `o_tri_id`  out  ID_W  nearest triangle.
- `o_ovf`  out  1  at least one beat of this ray had overflow.
- `o_count`  out  CNT_W  beats consumed for this ray.

## Operation
- FSM states: ACCUM and RESULT. Reset goes to ACCUM.
- `o_ready` = (state == ACCUM). `o_valid` = (state == RESULT).
- Accept: `i_valid && o_ready`. On each accept:
  - count += 1, saturating at all-ones.
  - `ovf |= i_overflow`.
- A beat qualifies when `i_hit && !i_overflow && i_t <= T_MAX`. The comparison is signed 32-bit.
- A qualifying beat replaces the best record when `!have_hit || i_t < best_t`. The compare is strict, so on equal t the earlier triangle is kept.
- When the best record is replaced, `have_hit` is set to 1 and best t/a/b/id are loaded.
- An accept with `i_last = 1` applies the same update and moves the FSM to RESULT.
- In RESULT, outputs are driven from the registers, with `o_hit = have_hit`.
  - With `o_hit = 0`, `o_t = T_MAX`, `o_a = o_b = 0` and `o_tri_id = 0`.
- In RESULT, `o_valid && i_ready` clears have_hit, ovf and count, and returns the FSM to ACCUM.
- Upstream beats are not accepted during RESULT. Input fields are don't-care when `i_valid = 0`.

## Timing
- Reset (async assert, sync-safe deassert):
  - state ACCUM, have_hit 0, count 0, ovf 0, best_t T_MAX, best a/b/id 0.
  - Outputs: `o_valid` 0, `o_ready` 1, and `o_hit`/`o_ovf`/`o_count` 0.
- Latency: `o_valid` rises in the cycle after the last beat is accepted.
- Bubble: the stage is ready again in the cycle after the record is accepted, giving one dead cycle between rays.
- Every output is a register or a decode of the FSM state. There are no combinational paths from inputs to outputs.
- `o_valid` and the record hold stable until `i_ready` is seen. Backpressure of any length is tolerated.
- A single-beat ray (`i_last` on the first beat) is legal.
- Count saturation does not affect the hit logic.
- Reset asserted mid-ray or during RESULT discards the partial ray and the pending record.

## Structure
- Shared package `raytrace_pkg`:
  - `fip32_t`, a signed [31:0] Q16.16 type.
  - `FIP_ONE` = 32'sh0001_0000.
  - A `hit_rec_t` struct holding hit, t, a, b and tri_id.
  - The FSM state enum.
- One sub-module, `closest_hit_cmp`, is natural: a combinational block that computes the qualify flag and the replace flag from the beat fields and the best record. It keeps the compare rule in one place for reuse in a later multi-ray version.

## Test plan
- 3-beat ray: t = 5.0, 2.0, 3.0, all hits. Expect `o_hit` 1, `o_t` 32'sh0002_0000, id of beat 2, `o_count` 3.
- Ray where all beats have `i_hit` 0. Expect `o_hit` 0, `o_t` T_MAX, `o_tri_id` 0, `o_ovf` 0.
- Tie at t = 1.0 on ids 7 then 9. Expect `o_tri_id` 7.
- Beat with `i_overflow` 1 and t = 0.5, then a clean hit at t = 4.0. Expect `o_t` 4.0, `o_ovf` 1.
- Hold `i_ready` low 10 cycles with `i_valid` high. Expect the record stable, `o_ready` 0 and no beats consumed. After the handshake, `o_ready` is 1 the next cycle.
- Assert `i_rstn` low mid-ray after 2 beats. Expect all outputs at reset values. The next ray's result excludes the earlier beats.
